axi_info_reader: RTL and testbench
==================================

# axi_info_reader

AXI-lite read initiator that fetches N consecutive 32-bit words from a read-only info slave (e.g. a compiled-in info ROM) and forwards them, in address order, on an AXI-stream output. It sits on the control side of a design, where a local controller or debug path needs the info contents as a stream instead of issuing register reads itself. One read is outstanding at a time. Responses other than OKAY are flagged per word and summarised in a sticky error bit.

## Interface
- N, 4: number of words per run; N ≥ 1.
- ADDR_WIDTH, 32: ARADDR width.
- DATA_WIDTH, 32: RDATA/tdata width; multiple of 8.
- BASE, '0: byte address of word 0.
- STRIDE, DATA_WIDTH/8: byte increment between consecutive words.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  run request; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  single-cycle pulse when the run has completed.
- err  out  1  sticky; set if any RRESP ≠ OKAY; cleared by an accepted start.
- m_axi_ARVALID  out  1  read address valid.
- m_axi_ARREADY  in  1  read address ready.
- m_axi_ARADDR  out  ADDR_WIDTH  BASE + idx*STRIDE.
- m_axi_ARPROT  out  3  constant 3'b000.
- m_axi_RVALID  in  1  read data valid.
- m_axi_RREADY  out  1  read data ready.
- m_axi_RDATA  in  DATA_WIDTH  read data.
- m_axi_RRESP  in  2  read response.
- m_axis_tvalid  out  1  output word valid.
- m_axis_tready  in  1  output word ready.
- m_axis_tdata  out  DATA_WIDTH  RDATA of the word.
- m_axis_tuser  out  1  word carried RRESP ≠ OKAY.
- m_axis_tlast  out  1  marks word N-1.

## Operation
- FSM states: IDLE, ADDR, RESP, DRAIN.
- IDLE: start=1 → idx:=0, err:=0, go to ADDR. Start is ignored in every other state.
- ADDR: ARVALID=1 and ARADDR stable until the AR handshake. On ARVALID&&ARREADY → RESP.
- RESP: RREADY = !ovalid || m_axis_tready, where ovalid is the one-entry output register. On an R handshake:
  - the output register loads tdata=RDATA, tuser=(RRESP≠0), tlast=(idx==N-1);
  - err |= (RRESP≠0);
  - if idx==N-1 → DRAIN; otherwise idx++ and → ADDR.
- DRAIN: stays in DRAIN until the output register is empty or is being accepted this cycle. Then it pulses done, deasserts busy and returns to IDLE.
- Errored words are still forwarded with RDATA as received. The run never aborts on an error.
- idx is $clog2(N)-bit, minimum 1 bit. Address is computed modulo 2^ADDR_WIDTH and wraps silently.
- The output register is independent of the FSM. tvalid holds until tready, and a load and an unload may happen in the same cycle.

## Timing
- Reset values: ARVALID=0, RREADY=0, tvalid=0, tuser=0, tlast=0, busy=0, done=0, err=0, ARADDR=BASE, FSM in IDLE, idx=0.
- Start accepted in cycle t → ARVALID=1 and busy=1 in cycle t+1.
- Per word, minimum 2 cycles: one AR handshake cycle, then one R handshake cycle (R never precedes AR).
- Word k appears on tvalid one cycle after its R handshake.
- With ARREADY, RVALID and tready held at 1, N=4: tvalid pulses in cycles t+3, t+5, t+7, t+9 and done pulses in cycle t+9.
- Backpressure: while tready=0 and ovalid=1, RREADY=0. ARVALID is still issued for the next word.
- Reset mid-run: all state clears on the next edge and any outstanding AR/R is abandoned. The slave must be reset in the same cycle.

## Structure
- Package axi_info_pkg holds:
  - resp_e enum: OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3;
  - state_e enum: IDLE, ADDR, RESP, DRAIN.
- No sub-module is required. The output register is inline. If it is factored out, name it axis_out_reg.

## Test plan
- Back-to-back run, no stall: slave at N=4 returns DATA={0x11,0x22,0x33,0x44}, start pulsed → stream 0x11..0x44, tlast on 0x44, err=0, done exactly at t+9.
- Output backpressure: tready=0 for 5 cycles after the first word → RREADY held low, no word lost or duplicated, order preserved.
- Slave stalls: ARREADY delayed 3 cycles, RVALID delayed 2 cycles → ARADDR values are 0x0, 0x4, 0x8, 0xC each held stable until the handshake.
- Error response: word 2 answers RRESP=2'b11 → tuser=1 on word 2 only, err=1 after that word and held past done, cleared by the next start.
- Start while busy: start pulsed mid-run → ignored, exactly N words and a single done pulse.
- Reset mid-run: rst asserted during RESP with ovalid=1 → the next cycle shows tvalid=0, ARVALID=0, busy=0, err=0, and a fresh start completes normally.

Source files
------------

// File: rtl/axi_info_pkg.sv
// Shared types for the info-ROM stream reader: AXI read responses and FSM states.
package axi_info_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'd0,
      EXOKAY = 2'd1,
      SLVERR = 2'd2,
      DECERR = 2'd3
   } resp_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADDR  = 2'd1,
      RESP  = 2'd2,
      DRAIN = 2'd3
   } state_e;

   // Word index width; a single-word run still needs one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/axi_info_reader.sv
// Reads N consecutive words over AXI-lite, one read outstanding, and forwards
// them in address order on an AXI-stream output with a sticky error summary.
//
// state | meaning
// IDLE  | waiting for start
// ADDR  | AR issued for word idx, waiting for ARREADY
// RESP  | waiting for R of word idx; RREADY only when the output slot frees
// DRAIN | last word loaded, waiting for the output register to empty
module axi_info_reader
   import axi_info_pkg::*;
#(
   parameter int                    N          = 4,
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE       = '0,
   parameter int                    STRIDE     = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic                  m_axi_ARVALID,
   input  logic                  m_axi_ARREADY,
   output logic [ADDR_WIDTH-1:0] m_axi_ARADDR,
   output logic [2:0]            m_axi_ARPROT,
   input  logic                  m_axi_RVALID,
   output logic                  m_axi_RREADY,
   input  logic [DATA_WIDTH-1:0] m_axi_RDATA,
   input  logic [1:0]            m_axi_RRESP,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tuser,
   output logic                  m_axis_tlast
);

   localparam int               IDX_W    = idx_width(N);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   state_e           state, state_nxt;
   logic [IDX_W-1:0] idx;
   logic             ar_hs;
   logic             r_hs;
   logic             resp_bad;
   logic             out_free;
   logic             is_last;

   assign ar_hs    = m_axi_ARVALID && m_axi_ARREADY;
   assign r_hs     = m_axi_RVALID && m_axi_RREADY;
   assign resp_bad = (m_axi_RRESP != OKAY);
   assign out_free = !m_axis_tvalid || m_axis_tready;
   assign is_last  = (idx == LAST_IDX);

   assign m_axi_ARVALID = (state == ADDR);
   assign m_axi_ARPROT  = 3'b000;
   // Address wraps modulo 2^ADDR_WIDTH by construction of the sized arithmetic.
   assign m_axi_ARADDR  = BASE + ADDR_WIDTH'(idx) * ADDR_WIDTH'(STRIDE);
   assign m_axi_RREADY  = (state == RESP) && out_free;

   assign busy = (state != IDLE);
   assign done = (state == DRAIN) && out_free;

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = ADDR;
         ADDR:    if (ar_hs) state_nxt = RESP;
         RESP:    if (r_hs)  state_nxt = is_last ? DRAIN : ADDR;
         DRAIN:   if (out_free) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && start) begin
            idx <= '0;
            err <= 1'b0;
         end else if (r_hs) begin
            err <= err | resp_bad;
            if (!is_last) idx <= idx + 1'b1;
         end
      end
   end

   // One-entry output register; load and unload may coincide.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tuser  <= 1'b0;
         m_axis_tlast  <= 1'b0;
      end else if (r_hs) begin
         m_axis_tvalid <= 1'b1;
         m_axis_tdata  <= m_axi_RDATA;
         m_axis_tuser  <= resp_bad;
         m_axis_tlast  <= is_last;
      end else if (m_axis_tready) begin
         m_axis_tvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axi_info_reader.sv
// Scoreboard bench for axi_info_reader with a delay-configurable AXI-lite slave.
module tb_axi_info_reader;
   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        busy, done, err;
   logic        arvalid, arready;
   logic [31:0] araddr;
   logic [2:0]  arprot;
   logic        rvalid, rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        tvalid, tuser, tlast;
   logic        tready = 1'b1;
   logic [31:0] tdata;

   typedef struct packed {
      logic [31:0] data;
      logic        user;
      logic        last;
   } word_t;

   word_t       exp_q[$];
   logic [31:0] addr_q[$];
   logic [31:0] mem[N];
   logic [1:0]  resp_tab[N];
   int          ar_delay = 0;
   int          r_delay = 0;
   int          n_checks = 0;
   int          n_fails = 0;
   int          done_cnt = 0;
   int          word_cnt = 0;

   axi_info_reader #(.N(N), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
      .m_axi_ARVALID(arvalid), .m_axi_ARREADY(arready), .m_axi_ARADDR(araddr),
      .m_axi_ARPROT(arprot), .m_axi_RVALID(rvalid), .m_axi_RREADY(rready),
      .m_axi_RDATA(rdata), .m_axi_RRESP(rresp),
      .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tdata(tdata),
      .m_axis_tuser(tuser), .m_axis_tlast(tlast)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1, "watchdog");
   end

   // AXI-lite slave: handshakes sampled at negedge, responses driven after posedge.
   initial begin : slave
      logic        ar_hs_s, r_hs_s, rst_s, pend, prev_wait;
      logic [31:0] hs_addr, prev_addr, exp_addr;
      int          ar_wait, r_wait, ridx;
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
      pend = 1'b0; prev_wait = 1'b0; prev_addr = '0; hs_addr = '0;
      ar_wait = 0; r_wait = 0; ridx = 0;
      forever begin
         @(negedge clk);
         rst_s   = rst;
         ar_hs_s = arvalid && arready;
         r_hs_s  = rvalid && rready;
         hs_addr = araddr;
         if (!rst_s && arvalid) begin
            if (prev_wait) begin
               n_checks++;
               if (araddr !== prev_addr) begin
                  n_fails++;
                  $display("FAIL araddr_stable: got %h, required %h", araddr, prev_addr);
               end
            end
            if (ar_hs_s) begin
               n_checks++;
               if (addr_q.size() == 0) begin
                  n_fails++;
                  $display("FAIL ar_unexpected: got addr %h, required no AR", araddr);
               end else begin
                  exp_addr = addr_q.pop_front();
                  if (araddr !== exp_addr) begin
                     n_fails++;
                     $display("FAIL araddr: got %h, required %h", araddr, exp_addr);
                  end
               end
            end
         end
         prev_wait = !rst_s && arvalid && !arready;
         prev_addr = araddr;
         @(posedge clk); #1;
         if (rst_s) begin
            pend = 1'b0; arready = 1'b0; rvalid = 1'b0; ar_wait = 0; r_wait = 0;
         end else begin
            if (r_hs_s) begin
               pend = 1'b0; rvalid = 1'b0;
            end
            if (ar_hs_s) begin
               pend = 1'b1; r_wait = 0; ar_wait = 0;
               ridx = int'((hs_addr >> 2) & 32'h3);
            end
            if (arvalid && !pend) begin
               if (ar_wait >= ar_delay) arready = 1'b1;
               else begin arready = 1'b0; ar_wait++; end
            end else begin
               arready = 1'b0;
            end
            if (pend && !rvalid) begin
               if (r_wait >= r_delay) begin
                  rvalid = 1'b1; rdata = mem[ridx]; rresp = resp_tab[ridx];
               end else begin
                  r_wait++;
               end
            end
         end
      end
   end

   // Stream monitor: pops the scoreboard on every accepted output word.
   always @(negedge clk) begin
      word_t w;
      if (!rst) begin
         if (done) done_cnt++;
         if (tvalid && tready) begin
            word_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fails++;
               $display("FAIL stream_extra: got data %h, required no word", tdata);
            end else begin
               w = exp_q.pop_front();
               if ({tdata, tuser, tlast} !== w) begin
                  n_fails++;
                  $display("FAIL stream_word: got %h/u%b/l%b, required %h/u%b/l%b",
                           tdata, tuser, tlast, w.data, w.user, w.last);
               end
            end
         end
      end
   end

   task automatic cycle();
      @(posedge clk); #1;
   endtask

   task automatic set_tables(input logic [31:0] seed);
      for (int k = 0; k < N; k++) begin
         mem[k]      = seed + 32'(k) * 32'h11;
         resp_tab[k] = 2'b00;
      end
   endtask

   task automatic push_run();
      for (int k = 0; k < N; k++) begin
         exp_q.push_back({mem[k], resp_tab[k] != 2'b00, k == N - 1});
         addr_q.push_back(32'(k * 4));
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cycle();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      bit ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin ok = 1; break; end
      end
      n_checks++;
      if (!ok) begin
         n_fails++;
         $display("FAIL done_timeout: got no done, required done within %0d cycles", budget);
      end
      cycle();
   endtask

   task automatic check_drained(input string name);
      n_checks++;
      if (exp_q.size() != 0 || addr_q.size() != 0) begin
         n_fails++;
         $display("FAIL %s_drained: got %0d words/%0d addrs left, required 0/0",
                  name, exp_q.size(), addr_q.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; tready = 1'b1;
      repeat (3) cycle();
      @(negedge clk);
      n_checks++;
      if ({arvalid, rready, tvalid, tuser, tlast, busy, done, err} !== 8'b0) begin
         n_fails++;
         $display("FAIL reset_outputs: got %b, required 00000000",
                  {arvalid, rready, tvalid, tuser, tlast, busy, done, err});
      end
      n_checks++;
      if (araddr !== 32'h0 || arprot !== 3'b000) begin
         n_fails++;
         $display("FAIL reset_addr: got %h/%b, required 00000000/000", araddr, arprot);
      end
      cycle();
      rst = 1'b0;
      cycle();
   endtask

   task automatic test_back_to_back();
      logic [12:0] tv_m = '0, dn_m = '0, bz_m = '0;
      int dc0 = done_cnt;
      ar_delay = 0; r_delay = 0; tready = 1'b1;
      mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
      for (int k = 0; k < N; k++) resp_tab[k] = 2'b00;
      push_run();
      start = 1'b1;
      @(negedge clk);
      bz_m[0] = busy;
      for (int k = 1; k <= 12; k++) begin
         cycle();
         if (k == 1) start = 1'b0;
         @(negedge clk);
         tv_m[k] = tvalid; dn_m[k] = done; bz_m[k] = busy;
      end
      n_checks++;
      if (tv_m !== 13'h02A8) begin
         n_fails++;
         $display("FAIL b2b_tvalid_cycles: got %h, required 02a8", tv_m);
      end
      n_checks++;
      if (dn_m !== 13'h0200) begin
         n_fails++;
         $display("FAIL b2b_done_cycle: got %h, required 0200", dn_m);
      end
      n_checks++;
      if (bz_m !== 13'h03FE) begin
         n_fails++;
         $display("FAIL b2b_busy_cycles: got %h, required 03fe", bz_m);
      end
      n_checks++;
      if (err !== 1'b0 || done_cnt - dc0 != 1) begin
         n_fails++;
         $display("FAIL b2b_err_done: got err %b dones %0d, required err 0 dones 1", err, done_cnt - dc0);
      end
      check_drained("b2b");
      cycle();
   endtask

   task automatic test_backpressure();
      int viol = 0, ar_seen = 0, stalled = 0, wc0 = word_cnt;
      ar_delay = 0; r_delay = 0; tready = 1'b1;
      set_tables(32'hDEAD_0001);
      push_run();
      pulse_start();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (tvalid) break;
      end
      cycle();
      tready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (tvalid && rready) viol++;
         if (arvalid) ar_seen++;
         if (rvalid && !rready) stalled++;
         cycle();
      end
      n_checks++;
      if (viol != 0 || ar_seen == 0 || stalled == 0 || tvalid !== 1'b1) begin
         n_fails++;
         $display("FAIL bp_rready: got viol %0d ar %0d stall %0d tvalid %b, required 0 >0 >0 1",
                  viol, ar_seen, stalled, tvalid);
      end
      tready = 1'b1;
      wait_done(100);
      n_checks++;
      if (word_cnt - wc0 != N) begin
         n_fails++;
         $display("FAIL bp_count: got %0d words, required %0d", word_cnt - wc0, N);
      end
      check_drained("bp");
   endtask

   task automatic test_slave_stall();
      ar_delay = 3; r_delay = 2; tready = 1'b1;
      set_tables(32'h0000_0011);
      push_run();
      pulse_start();
      wait_done(200);
      n_checks++;
      if (err !== 1'b0 || busy !== 1'b0) begin
         n_fails++;
         $display("FAIL stall_status: got err %b busy %b, required 0 0", err, busy);
      end
      check_drained("stall");
      ar_delay = 0; r_delay = 0;
   endtask

   task automatic test_error();
      bit ok = 0;
      int k = 0;
      set_tables(32'hCAFE_0100);
      resp_tab[2] = 2'b11;
      push_run();
      pulse_start();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tvalid && tready) begin
            n_checks++;
            if (err !== (k >= 2)) begin
               n_fails++;
               $display("FAIL err_progress: word %0d got err %b, required %b", k, err, k >= 2);
            end
            k++;
         end
         if (done) begin ok = 1; break; end
      end
      n_checks++;
      if (!ok) begin
         n_fails++;
         $display("FAIL err_timeout: got no done, required done");
      end
      repeat (3) cycle();
      @(negedge clk);
      n_checks++;
      if (err !== 1'b1) begin
         n_fails++;
         $display("FAIL err_sticky: got %b, required 1", err);
      end
      check_drained("err");
      cycle();
      resp_tab[2] = 2'b00;
      push_run();
      pulse_start();
      @(negedge clk);
      n_checks++;
      if (err !== 1'b0) begin
         n_fails++;
         $display("FAIL err_clear: got %b, required 0", err);
      end
      wait_done(100);
      check_drained("err2");
   endtask

   task automatic test_start_busy();
      int wc0 = word_cnt, dc0 = done_cnt;
      set_tables(32'h5000_0000);
      push_run();
      pulse_start();
      for (int i = 0; i < 25; i++) begin
         start = (i >= 2 && i <= 5);
         cycle();
      end
      start = 1'b0;
      n_checks++;
      if (word_cnt - wc0 != N || done_cnt - dc0 != 1 || busy !== 1'b0) begin
         n_fails++;
         $display("FAIL start_busy: got %0d words %0d dones busy %b, required %0d 1 0",
                  word_cnt - wc0, done_cnt - dc0, busy, N);
      end
      check_drained("sbusy");
   endtask

   task automatic test_reset_midrun();
      bit found = 0;
      set_tables(32'h7700_0000);
      resp_tab[0] = 2'b10;
      tready = 1'b0;
      push_run();
      pulse_start();
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (tvalid && busy && !arvalid) begin found = 1; break; end
      end
      n_checks++;
      if (!found || err !== 1'b1) begin
         n_fails++;
         $display("FAIL rstmid_setup: got found %b err %b, required 1 1", found, err);
      end
      cycle();
      rst = 1'b1;
      exp_q.delete();
      addr_q.delete();
      cycle();
      @(negedge clk);
      n_checks++;
      if ({tvalid, arvalid, busy, err} !== 4'b0000) begin
         n_fails++;
         $display("FAIL rstmid_clear: got %b, required 0000", {tvalid, arvalid, busy, err});
      end
      cycle();
      rst = 1'b0;
      tready = 1'b1;
      resp_tab[0] = 2'b00;
      cycle();
      push_run();
      pulse_start();
      wait_done(100);
      n_checks++;
      if (err !== 1'b0) begin
         n_fails++;
         $display("FAIL rstmid_rerun_err: got %b, required 0", err);
      end
      check_drained("rstmid");
   endtask

   initial begin
      set_tables(32'h0);
      test_reset();
      test_back_to_back();
      test_backpressure();
      test_slave_stall();
      test_error();
      test_start_busy();
      test_reset_midrun();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
